// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives imem_addr, fills the IF/ID register.
// Optional HALT opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              is_halt;

  assign imem_addr = pc;

`ifdef FETCH_HALT_DETECT_EN
  assign is_halt = (imem_data[INSTR_W-1 -: 6] == 6'b111111);
  assign halted  = (state == HALTED);
`else
  assign is_halt = 1'b0;
  assign halted  = 1'b0;
`endif

  // Priority: rst > redirect > stall > HALTED > normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr_out   <= '0;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      fetch_count <= '0;
      state       <= FETCH;
    end else if (redirect) begin
      pc        <= redirect_pc;
      instr_out <= '0;
      valid_out <= 1'b0;
      state     <= FETCH;
    end else if (!stall) begin
      case (state)
        HALTED: begin
          instr_out <= '0;
          valid_out <= 1'b0;
        end
        FETCH: begin
          instr_out <= imem_data;
          pc_out    <= pc;
          valid_out <= 1'b1;
          if (fetch_count != '1)
            fetch_count <= fetch_count + CNT_W'(1);
          // A HALT is issued normally but parks the PC on itself.
          if (is_halt)
            state <= HALTED;
          else
            pc <= pc + ADDR_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors plus a per-cycle reference model.
module tb_fetch_stage;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;
  localparam int MAX_CNT = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst;
  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               valid_out;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  logic [INSTR_W-1:0] imem [256];

  int pass_count  = 0;
  int check_count = 0;

  // Reference model state, updated from inputs on each rising edge.
  bit          model_ready = 0;
  int          m_pc;
  logic [31:0] m_instr;
  int          m_pc_out;
  bit          m_valid;
  int          m_count;
  bit          m_halt;

  fetch_stage #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out),
    .halted(halted), .fetch_count(fetch_count)
  );

  assign imem_data = imem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp)
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    else
      pass_count++;
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit rd, input logic [7:0] rpc);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [31:0] w;
    bit          halt_en;
`ifdef FETCH_HALT_DETECT_EN
    halt_en = 1;
`else
    halt_en = 0;
`endif
    model_ready <= 1;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pc_out = 0; m_valid = 0; m_count = 0; m_halt = 0;
    end else if (redirect) begin
      m_pc = int'(redirect_pc); m_instr = 0; m_valid = 0; m_halt = 0;
    end else if (stall) begin
      // everything holds
    end else if (m_halt) begin
      m_instr = 0; m_valid = 0;
    end else begin
      w        = imem[m_pc];
      m_instr  = w;
      m_pc_out = m_pc;
      m_valid  = 1;
      if (m_count < MAX_CNT) m_count = m_count + 1;
      if (halt_en && w[31:26] == 6'h3F) m_halt = 1;
      else m_pc = (m_pc + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("model_instr", instr_out, m_instr);
      checkOutput("model_pc_out", 32'(pc_out), 32'(m_pc_out));
      checkOutput("model_valid", 32'(valid_out), 32'(m_valid));
      checkOutput("model_count", 32'(fetch_count), 32'(m_count));
      checkOutput("model_addr", 32'(imem_addr), 32'(m_pc));
      checkOutput("model_halted", 32'(halted), 32'(m_halt));
    end
  end

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000 + i;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_valid", 32'(valid_out), 0);
    checkOutput("reset_instr", instr_out, 0);
    checkOutput("reset_count", 32'(fetch_count), 0);
    checkOutput("reset_addr", 32'(imem_addr), 0);

    // Sequential fetch, then stall after pc_out=2
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("seq_pc", 32'(pc_out), i);
      checkOutput("seq_instr", instr_out, 32'h1000 + i);
      checkOutput("seq_valid", 32'(valid_out), 1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("stall_pc", 32'(pc_out), 2);
      checkOutput("stall_instr", instr_out, 32'h1002);
      checkOutput("stall_count", 32'(fetch_count), 3);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("unstall_pc", 32'(pc_out), 3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("seq5_instr", instr_out, 32'h1004);
    checkOutput("seq5_count", 32'(fetch_count), 5);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre_rst_pc", 32'(pc_out), 6);
    checkOutput("pre_rst_count", 32'(fetch_count), 7);

    // Reset mid-run
    applyStimulus(1, 0, 0, 0);
    checkOutput("midrst_valid", 32'(valid_out), 0);
    checkOutput("midrst_pc", 32'(pc_out), 0);
    checkOutput("midrst_count", 32'(fetch_count), 0);
    checkOutput("midrst_instr", instr_out, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("postrst_pc", 32'(pc_out), 0);
    checkOutput("postrst_instr", instr_out, 32'h1000);
    checkOutput("postrst_count", 32'(fetch_count), 1);

    // Redirect while stalled
    applyStimulus(0, 1, 1, 8'h40);
    checkOutput("redir_valid", 32'(valid_out), 0);
    checkOutput("redir_instr", instr_out, 0);
    checkOutput("redir_addr", 32'(imem_addr), 32'h40);
    applyStimulus(0, 0, 0, 0);
    checkOutput("redir_tgt_pc", 32'(pc_out), 32'h40);
    checkOutput("redir_tgt_instr", instr_out, 32'h1040);

    // Wrap from 0xFF to 0x00
    applyStimulus(0, 0, 1, 8'hFF);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_pc_ff", 32'(pc_out), 32'hFF);
    applyStimulus(0, 0, 0, 0);
    checkOutput("wrap_pc_00", 32'(pc_out), 0);
    checkOutput("wrap_valid", 32'(valid_out), 1);
    checkOutput("wrap_instr", instr_out, 32'h1000);

    // Counter saturation
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("sat_pc", 32'(pc_out), 14);
    checkOutput("sat_count", 32'(fetch_count), MAX_CNT);

    // HALT opcode
    imem[3] = 32'hFC000000;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("halt_issue_pc", 32'(pc_out), 3);
    checkOutput("halt_issue_instr", instr_out, 32'hFC000000);
    checkOutput("halt_issue_valid", 32'(valid_out), 1);
`ifdef FETCH_HALT_DETECT_EN
    checkOutput("halt_flag", 32'(halted), 1);
    checkOutput("halt_addr", 32'(imem_addr), 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("halted_valid", 32'(valid_out), 0);
      checkOutput("halted_addr", 32'(imem_addr), 3);
      checkOutput("halted_flag", 32'(halted), 1);
    end
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("unhalt_flag", 32'(halted), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("resume_pc", 32'(pc_out), 0);
    checkOutput("resume_valid", 32'(valid_out), 1);
`else
    checkOutput("nohalt_flag", 32'(halted), 0);
    checkOutput("nohalt_addr", 32'(imem_addr), 4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("nohalt_pc", 32'(pc_out), 4);
    checkOutput("nohalt_instr", instr_out, 32'h1004);
`endif

    applyStimulus(0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined `cpu`: the first stage, upstream of decode. It owns the program counter and drives the instruction-memory address. It registers the fetched instruction and its PC into the IF/ID pipeline register. It honours stall (hold) and redirect/flush requests from later stages and can halt on a HALT opcode.

## Interface
- `ADDR_W`, default 8: PC / instruction-memory address width, in words.
- `INSTR_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `CNT_W`, default 16: width of the fetched-instruction counter.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold the PC and the IF/ID register.
- `redirect`  in  1: taken branch/jump; flush and load the PC.
- `redirect_pc`  in  ADDR_W: target for `redirect`.
- `imem_addr`  out  ADDR_W: instruction-memory address; combinationally equal to the PC.
- `imem_data`  in  INSTR_W: instruction at `imem_addr`, valid in the same cycle (asynchronous read).
- `instr_out`  out  INSTR_W: IF/ID instruction.
- `pc_out`  out  ADDR_W: IF/ID PC of `instr_out`.
- `valid_out`  out  1: IF/ID holds a real instruction; 0 means bubble.
- `halted`  out  1: the fetch state machine is in HALTED.
- `fetch_count`  out  CNT_W: number of instructions issued with `valid_out`=1, saturating.

## Operation
- State machine has two states: FETCH and HALTED. Reset enters FETCH.
- Per-edge priority is `rst` > `redirect` > `stall` > HALTED > normal fetch.
- **Reset:** PC=RESET_PC, `instr_out`=0, `pc_out`=0, `valid_out`=0, `fetch_count`=0, `halted`=0.
- **Redirect:**
  - PC <= `redirect_pc`, `instr_out` <= 0, `valid_out` <= 0, and `pc_out` holds.
  - State <= FETCH. This applies in either state, even with `stall` high.
- **Stall (no redirect):** PC, `instr_out`, `pc_out`, `valid_out`, state and `fetch_count` all hold.
- **HALTED (no stall/redirect):** PC holds, `valid_out` <= 0, `instr_out` <= 0, and nothing is fetched.
- **Normal fetch:**
  - `instr_out` <= `imem_data`, `pc_out` <= PC, `valid_out` <= 1.
  - PC <= PC+1, modulo 2^ADDR_W: `{ADDR_W{1'b1}}` wraps to 0 with no error.
  - `fetch_count` <= `fetch_count`+1, saturating at all-ones.
- **HALT opcode:** `imem_data[INSTR_W-1:INSTR_W-6]` == 6'b111111; see Configuration.
  - When fetched normally, it is issued like any instruction (`valid_out`=1, counted).
  - PC does not advance and the state moves to HALTED.

## Timing
- Fetch latency is 1 cycle: the `imem_data` presented while PC=A appears on `instr_out` with `pc_out`=A after the next edge.
- The first valid instruction appears on the first edge with `rst`=0. `valid_out` is 1 from that edge on.
- `imem_addr` changes only on clock edges, from PC updates. It shows `redirect_pc` in the cycle after a redirect edge.
- A redirect produces exactly one bubble, followed by the target instruction on the following edge, provided there is no stall.
- `stall` takes effect on the edge where it is sampled high. The outputs in that cycle are repeated until it drops.
- `rst` asserted mid-stream overrides everything on that edge. No partial update is allowed.
- `halted` is a registered output. It is 1 on the edge after the HALT instruction is issued, which is the same edge `instr_out` shows HALT.

## Configuration
- Macro: `FETCH_HALT_DETECT_EN`.
- **Defined:** HALT opcode detection and the HALTED state behave as above.
- **Undefined:**
  - The HALT opcode is an ordinary instruction and the state machine stays in FETCH.
  - `halted` is tied to 0.
  - Every other behaviour is identical.

## Test plan
- **Sequential fetch:**
  - Stimulus: imem[i]=0x1000+i, RESET_PC=0, reset 2 cycles, then run 5 cycles.
  - Response: `instr_out` = 0x1000..0x1004, `pc_out` = 0..4, `valid_out`=1, `fetch_count`=5.
- **Stall:**
  - Stimulus: `stall` high for 3 cycles after `pc_out`=2.
  - Response: outputs hold `pc_out`=2 and instr 0x1002, `fetch_count` frozen. After release the next issued `pc_out` is 3.
- **Redirect:**
  - Stimulus: `redirect`=1 with `redirect_pc`=0x40 while `stall`=1.
  - Response: next edge gives `valid_out`=0 and `instr_out`=0. The edge after gives `pc_out`=0x40 with instr 0x1040.
- **Wrap:**
  - Stimulus: redirect to 0xFF, then run 2 cycles.
  - Response: `pc_out` = 0xFF then 0x00, with no bubble.
- **Halt (macro defined):**
  - Stimulus: imem[3]=0xFC000000.
  - Response: HALT issued with `pc_out`=3, `halted`=1, then `valid_out`=0 indefinitely with `imem_addr`=3. A redirect to 0 clears `halted` and resumes fetch. With the macro undefined, `pc_out` continues to 4.
- **Reset mid-run:**
  - Stimulus: `rst` asserted for 1 cycle with `pc_out`=6 and `fetch_count`=7.
  - Response: all outputs return to reset values. The next fetch issues `pc_out`=RESET_PC.
